// File: rtl/i2c_write_data.sv
// Bit-banged I2C write master: address byte, register pointer and 0-2 data bytes.
// Optional SCL clock stretching with timeout under `define I2C_CLOCK_STRETCH_EN.
module i2c_write_data #(
  parameter int unsigned ACK_CHECK       = 1,
  parameter int unsigned STRETCH_TIMEOUT = 255
) (
  input  logic        PT_CK,
  input  logic        RESET,
  input  logic        GO,
  input  logic [7:0]  SLAVE_ADDRESS,
  input  logic [7:0]  REG_ADDR,
  input  logic [15:0] DATA16,
  input  logic [1:0]  DATA_BYTES,
  input  logic        SDAI,
  input  logic        SCLI,
  output logic        SDAO,
  output logic        SCLO,
  output logic        END_OK,
  output logic        ACK_OK,
  output logic [2:0]  BYTE_CNT
);

  localparam int unsigned CNT_W  = 3;
  localparam int unsigned PH_W   = 2;
  localparam int unsigned BIT_W  = 4;
  localparam int unsigned BYTE_W = 8;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START_A,
    S_START_B,
    S_BIT,
    S_STOP0,
    S_STOP1,
    S_STOP2,
    S_DONE
  } state_t;

  state_t              state, state_nxt;
  logic                go_d;
  logic [BYTE_W-1:0]   addr_q, addr_nxt;
  logic [BYTE_W-1:0]   reg_q, reg_nxt;
  logic [15:0]         data_q, data_nxt;
  logic [CNT_W-1:0]    n_q, n_nxt;
  logic [PH_W-1:0]     phase_q, phase_nxt;
  logic [BIT_W-1:0]    bit_q, bit_nxt;
  logic                sdao_nxt, sclo_nxt, end_ok_nxt, ack_ok_nxt;
  logic [CNT_W-1:0]    byte_cnt_nxt;

  logic                go_edge_c;
  logic [BYTE_W-1:0]   cur_byte_c;
  logic                tx_bit_c;
  logic [CNT_W-1:0]    cnt_inc_c;
  logic                ack_slot_end_c;
  logic                stop_after_c;
  logic                stall_c;
  logic                timeout_c;

  assign go_edge_c = GO & ~go_d;
  assign cnt_inc_c = BYTE_CNT + CNT_W'(1);

  // Byte currently on the wire, selected by how many bytes have completed
  always_comb begin
    cur_byte_c = data_q[7:0];
    case (BYTE_CNT)
      3'd0:    cur_byte_c = addr_q;
      3'd1:    cur_byte_c = reg_q;
      3'd2:    cur_byte_c = data_q[15:8];
      default: cur_byte_c = data_q[7:0];
    endcase
  end

  assign tx_bit_c       = (bit_q == BIT_W'(8)) ? 1'b1 : cur_byte_c[3'(BIT_W'(7) - bit_q)];
  assign ack_slot_end_c = (state == S_BIT) && (phase_q == PH_W'(3)) &&
                          (bit_q == BIT_W'(8)) && !stall_c;
  assign stop_after_c   = (SDAI && (ACK_CHECK != 0)) || (cnt_inc_c == n_q);

`ifdef I2C_CLOCK_STRETCH_EN
  localparam int unsigned STALL_W = $clog2(STRETCH_TIMEOUT + 2);

  logic [STALL_W-1:0] stall_cnt;
  logic               unused_c;

  // Slave holds SCL low after we released it: freeze the phase
  assign stall_c   = SCLO && !SCLI &&
                     (((state == S_BIT) && (phase_q == PH_W'(3))) || (state == S_STOP2));
  assign timeout_c = stall_c && (stall_cnt >= STALL_W'(STRETCH_TIMEOUT));
  assign unused_c  = SLAVE_ADDRESS[0];

  always_ff @(posedge PT_CK or posedge RESET) begin
    if (RESET) begin
      stall_cnt <= '0;
    end else if (stall_c) begin
      stall_cnt <= stall_cnt + STALL_W'(1);
    end else begin
      stall_cnt <= '0;
    end
  end
`else
  logic unused_c;

  assign stall_c   = 1'b0;
  assign timeout_c = 1'b0;
  assign unused_c  = ^{SCLI, SLAVE_ADDRESS[0], 32'(STRETCH_TIMEOUT)};
`endif

  // State and datapath registers
  always_ff @(posedge PT_CK or posedge RESET) begin
    if (RESET) begin
      state    <= S_IDLE;
      go_d     <= 1'b0;
      addr_q   <= '0;
      reg_q    <= '0;
      data_q   <= '0;
      n_q      <= '0;
      phase_q  <= '0;
      bit_q    <= '0;
      SDAO     <= 1'b1;
      SCLO     <= 1'b1;
      END_OK   <= 1'b1;
      ACK_OK   <= 1'b0;
      BYTE_CNT <= '0;
    end else begin
      state    <= state_nxt;
      go_d     <= GO;
      addr_q   <= addr_nxt;
      reg_q    <= reg_nxt;
      data_q   <= data_nxt;
      n_q      <= n_nxt;
      phase_q  <= phase_nxt;
      bit_q    <= bit_nxt;
      SDAO     <= sdao_nxt;
      SCLO     <= sclo_nxt;
      END_OK   <= end_ok_nxt;
      ACK_OK   <= ack_ok_nxt;
      BYTE_CNT <= byte_cnt_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:    if (go_edge_c) state_nxt = S_START_A;
      S_START_A: state_nxt = S_START_B;
      S_START_B: state_nxt = S_BIT;
      S_BIT: begin
        if (timeout_c) begin
          state_nxt = S_STOP0;
        end else if (ack_slot_end_c && stop_after_c) begin
          state_nxt = S_STOP0;
        end
      end
      S_STOP0:   state_nxt = S_STOP1;
      S_STOP1:   state_nxt = S_STOP2;
      S_STOP2:   if (!stall_c || timeout_c) state_nxt = S_DONE;
      S_DONE:    state_nxt = S_IDLE;
      default:   state_nxt = S_IDLE;
    endcase
  end

  // Next values of line drives, status outputs and transaction latches
  always_comb begin
    addr_nxt     = addr_q;
    reg_nxt      = reg_q;
    data_nxt     = data_q;
    n_nxt        = n_q;
    phase_nxt    = phase_q;
    bit_nxt      = bit_q;
    sdao_nxt     = SDAO;
    sclo_nxt     = SCLO;
    end_ok_nxt   = END_OK;
    ack_ok_nxt   = ACK_OK;
    byte_cnt_nxt = BYTE_CNT;
    case (state)
      S_IDLE: begin
        sdao_nxt   = 1'b1;
        sclo_nxt   = 1'b1;
        end_ok_nxt = 1'b1;
        if (go_edge_c) begin
          addr_nxt     = {SLAVE_ADDRESS[7:1], 1'b0};
          reg_nxt      = REG_ADDR;
          data_nxt     = DATA16;
          n_nxt        = (DATA_BYTES == 2'd0) ? CNT_W'(2) :
                         (DATA_BYTES == 2'd1) ? CNT_W'(3) : CNT_W'(4);
          end_ok_nxt   = 1'b0;
          ack_ok_nxt   = 1'b1;
          byte_cnt_nxt = '0;
          phase_nxt    = '0;
          bit_nxt      = '0;
        end
      end
      S_START_A: sdao_nxt = 1'b0;
      S_START_B: sclo_nxt = 1'b0;
      S_BIT: begin
        if (timeout_c) begin
          ack_ok_nxt = 1'b0;
        end else if (!stall_c) begin
          phase_nxt = phase_q + PH_W'(1);
          case (phase_q)
            2'd0: begin
              sclo_nxt = 1'b0;
              sdao_nxt = tx_bit_c;
            end
            2'd2: sclo_nxt = 1'b1;
            2'd3: begin
              if (bit_q == BIT_W'(8)) begin
                bit_nxt      = '0;
                byte_cnt_nxt = cnt_inc_c;
                if (SDAI) ack_ok_nxt = 1'b0;
              end else begin
                bit_nxt = bit_q + BIT_W'(1);
              end
            end
            default: ;
          endcase
        end
      end
      S_STOP0: begin
        sclo_nxt = 1'b0;
        sdao_nxt = 1'b0;
      end
      S_STOP1: sclo_nxt = 1'b1;
      S_STOP2: begin
        if (!stall_c || timeout_c) sdao_nxt = 1'b1;
        if (timeout_c) ack_ok_nxt = 1'b0;
      end
      S_DONE:  end_ok_nxt = 1'b1;
      default: ;
    endcase
  end

endmodule
